pitch_glide_control: RTL and testbench

PITCH_GLIDE_CONTROL -- requirements
Module: pitch_glide_control

---
 rtl/pitch_glide_control.sv | 139 +++++++++++++
 tb/tb_pitch_glide_control.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pitch_glide_control.sv
// Per-slot portamento: each oscillator slot slews its phase increment toward
// the target by a fraction of the remaining distance once a glide is armed.
module pitch_glide_control #(
  parameter int VOICES   = 8,
  parameter int V_WIDTH  = 3,
  parameter int V_OSC    = 4,
  parameter int O_WIDTH  = 2,
  parameter int OE_WIDTH = 1,
  parameter int PITCH_W  = 24
) (
  input  logic                                  sCLK_XVXOSC,
  input  logic                                  reset,
  input  logic [V_WIDTH+O_WIDTH+OE_WIDTH-1:0]   xxxx,
  input  logic [PITCH_W-1:0]                    target_pitch,
  input  logic                                  note_on,
  input  logic [V_WIDTH-1:0]                    note_voice,
  input  logic                                  legato,
  input  logic                                  cfg_we,
  input  logic                                  cfg_adr,
  input  logic [7:0]                            cfg_data,
  output logic [PITCH_W-1:0]                    osc_pitch_val,
  output logic [VOICES-1:0]                     glide_active
);

  localparam int E_WIDTH = O_WIDTH + OE_WIDTH;
  localparam int S_WIDTH = V_WIDTH + O_WIDTH;
  localparam int SLOTS   = VOICES * V_OSC;

  localparam logic [1:0] MODE_ALWAYS = 2'd1;
  localparam logic [1:0] MODE_LEGATO = 2'd2;

  localparam logic [PITCH_W:0] STEP_MIN = {{PITCH_W{1'b0}}, 1'b1};

  logic [S_WIDTH-1:0] in_idx;
  logic [S_WIDTH-1:0] s1_idx;
  logic [PITCH_W-1:0] s1_tgt;

  logic [PITCH_W-1:0] cur [SLOTS];
  logic [SLOTS-1:0]   valid;
  logic [SLOTS-1:0]   gliding;
  logic [SLOTS-1:0]   gliding_nxt;
  logic [SLOTS-1:0]   set_mask;

  logic [7:0] glide_time;
  logic [7:0] glide_mode;

  logic [PITCH_W:0] rd_cur;
  logic [PITCH_W:0] tgt_x;
  logic [PITCH_W:0] diff;
  logic [PITCH_W:0] step_raw;
  logic [PITCH_W:0] step;
  logic [PITCH_W:0] mv;
  logic             up;
  logic             rd_valid;
  logic             rd_glide;
  logic [PITCH_W-1:0] wb_cur;
  logic             wb_glide;
  logic             start_ok;
  logic [VOICES-1:0] ga_nxt;

  logic unused_bits;
  assign unused_bits = ^{xxxx[OE_WIDTH-1:0], glide_time[7:4], glide_mode[7:2]};

  assign in_idx = {xxxx[V_WIDTH+E_WIDTH-1:E_WIDTH], xxxx[E_WIDTH-1:OE_WIDTH]};

  // Slot state is read combinationally at s1_idx, so a writeback from the
  // previous cycle is already visible here: back-to-back visits never see stale data.
  always_comb begin
    rd_cur   = {1'b0, cur[s1_idx]};
    rd_valid = valid[s1_idx];
    rd_glide = gliding[s1_idx];
    tgt_x    = {1'b0, s1_tgt};
    up       = (tgt_x >= rd_cur);
    diff     = up ? (tgt_x - rd_cur) : (rd_cur - tgt_x);
    step_raw = diff >> glide_time[3:0];
    step     = (step_raw == '0) ? STEP_MIN : step_raw;
    mv       = up ? (rd_cur + step) : (rd_cur - step);
    if (!rd_valid || !rd_glide || (diff <= step) || mv[PITCH_W]) begin
      wb_cur   = s1_tgt;
      wb_glide = 1'b0;
    end else begin
      wb_cur   = mv[PITCH_W-1:0];
      wb_glide = 1'b1;
    end
  end

  always_comb begin
    start_ok = note_on &&
               ((glide_mode[1:0] == MODE_ALWAYS) ||
                ((glide_mode[1:0] == MODE_LEGATO) && legato));
    for (int s = 0; s < SLOTS; s++) begin
      set_mask[s] = start_ok && ((s / V_OSC) == int'(note_voice));
    end
  end

  // A note_on arming a voice wins over the same-cycle writeback's gliding bit.
  always_comb begin
    gliding_nxt         = gliding;
    gliding_nxt[s1_idx] = wb_glide;
    gliding_nxt         = gliding_nxt | set_mask;
  end

  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      ga_nxt[v] = |gliding[v*V_OSC +: V_OSC];
    end
  end

  always_ff @(posedge sCLK_XVXOSC or posedge reset) begin
    if (reset) begin
      s1_idx        <= '0;
      s1_tgt        <= '0;
      osc_pitch_val <= '0;
      glide_active  <= '0;
      valid         <= '0;
      gliding       <= '0;
      glide_time    <= 8'h04;
      glide_mode    <= 8'h00;
    end else begin
      s1_idx         <= in_idx;
      s1_tgt         <= target_pitch;
      osc_pitch_val  <= wb_cur;
      glide_active   <= ga_nxt;
      valid[s1_idx]  <= 1'b1;
      gliding        <= gliding_nxt;
      if (cfg_we) begin
        unique case (1'b1)
          !cfg_adr: glide_time <= cfg_data;
          cfg_adr:  glide_mode <= cfg_data;
        endcase
      end
    end
  end

  always_ff @(posedge sCLK_XVXOSC) begin
    cur[s1_idx] <= wb_cur;
  end

endmodule

// File: tb/tb_pitch_glide_control.sv
// Bench for pitch_glide_control: directed glide scenarios plus random traffic
// against a per-visit behavioural model of the slot pitch state.
module tb_pitch_glide_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  xxxx;
  logic [23:0] target_pitch;
  logic        note_on;
  logic [2:0]  note_voice;
  logic        legato;
  logic        cfg_we;
  logic        cfg_adr;
  logic [7:0]  cfg_data;
  logic [23:0] osc_pitch_val;
  logic [7:0]  glide_active;

  always #5 clk = ~clk;

  pitch_glide_control dut (
    .sCLK_XVXOSC  (clk),
    .reset        (reset),
    .xxxx         (xxxx),
    .target_pitch (target_pitch),
    .note_on      (note_on),
    .note_voice   (note_voice),
    .legato       (legato),
    .cfg_we       (cfg_we),
    .cfg_adr      (cfg_adr),
    .cfg_data     (cfg_data),
    .osc_pitch_val(osc_pitch_val),
    .glide_active (glide_active)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // reference state: one entry per {voice,osc} slot
  longint      cur_m [32];
  bit          val_m [32];
  bit          gl_m  [32];
  int          shift_m;
  int          mode_m;
  int          pend_idx;
  longint      pend_tgt;
  longint      exp_osc;
  logic [7:0]  exp_ga;
  longint      tb_tgt [32];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      val_m[i] = 0;
      gl_m[i]  = 0;
    end
    shift_m  = 4;
    mode_m   = 0;
    pend_idx = 0;
    pend_tgt = 0;
    exp_osc  = 0;
    exp_ga   = '0;
  endfunction

  function automatic void model_visit(input int i, input longint t);
    longint c, d, s;
    c = cur_m[i];
    if (!val_m[i] || !gl_m[i]) begin
      c = t;
      gl_m[i] = 0;
    end else begin
      d = (t > c) ? t - c : c - t;
      s = d >> shift_m;
      if (s < 1) s = 1;
      if (d <= s) begin
        c = t;
        gl_m[i] = 0;
      end else begin
        c = (t > c) ? c + s : c - s;
      end
    end
    val_m[i] = 1;
    cur_m[i] = c;
    exp_osc  = c;
  endfunction

  // One clock edge worth of behaviour: the visit presented last cycle
  // completes, then this cycle's note_on and config write land.
  function automatic void model_edge();
    exp_ga = '0;
    for (int v = 0; v < 8; v++)
      for (int o = 0; o < 4; o++)
        if (gl_m[v*4+o]) exp_ga[v] = 1'b1;
    model_visit(pend_idx, pend_tgt);
    if (note_on && (mode_m == 1 || (mode_m == 2 && legato)))
      for (int o = 0; o < 4; o++) gl_m[int'(note_voice)*4+o] = 1;
    if (cfg_we) begin
      if (!cfg_adr) shift_m = int'(cfg_data) & 15;
      else          mode_m  = int'(cfg_data) & 3;
    end
    pend_idx = int'(xxxx) >> 1;
    pend_tgt = longint'(target_pitch);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("osc", {8'h0, osc_pitch_val}, 32'(exp_osc));
    check("gact", {24'h0, glide_active}, {24'h0, exp_ga});
  endtask

  task automatic visit(input int v, input int o, input int unsigned tgt);
    logic [31:0] vv, oo, tt;
    vv = v; oo = o; tt = tgt;
    xxxx         = {vv[2:0], oo[1:0], 1'b0};
    target_pitch = tt[23:0];
    step();
    note_on = 1'b0;
    cfg_we  = 1'b0;
    legato  = 1'b0;
  endtask

  task automatic cfg(input logic adr, input logic [7:0] data);
    cfg_we   = 1'b1;
    cfg_adr  = adr;
    cfg_data = data;
  endtask

  task automatic key(input int v, input logic leg);
    logic [31:0] vv;
    vv = v;
    note_on    = 1'b1;
    note_voice = vv[2:0];
    legato     = leg;
  endtask

  initial begin
    int k;
    bit reached;
    int lv, lo;
    reset = 1'b1;
    xxxx = '0; target_pitch = '0; note_on = 0; note_voice = '0;
    legato = 0; cfg_we = 0; cfg_adr = 0; cfg_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_osc", {8'h0, osc_pitch_val}, 32'h0);
    check("rst_gact", {24'h0, glide_active}, 32'h0);
    reset = 1'b0;

    // first visit snaps, two-cycle latency
    visit(2, 1, 24'h123456);
    visit(0, 0, 0);
    check("snap_val", {8'h0, osc_pitch_val}, 32'h123456);
    check("snap_gact", {24'h0, glide_active}, 32'h0);

    // mode always, shift 4: 0x100000 -> 0x200000
    cfg(1'b1, 8'h01);
    visit(0, 0, 24'h100000);
    key(0, 1'b0);
    visit(1, 0, 0);
    visit(0, 0, 24'h200000);
    visit(0, 0, 24'h200000);
    check("glide_s1", {8'h0, osc_pitch_val}, 32'h110000);
    visit(0, 0, 24'h200000);
    check("glide_s2", {8'h0, osc_pitch_val}, 32'h11F000);
    check("glide_act", {31'h0, glide_active[0]}, 32'h1);
    reached = 0;
    for (int n = 0; n < 400 && !reached; n++) begin
      visit(0, 0, 24'h200000);
      if (osc_pitch_val == 24'h200000) reached = 1;
    end
    check("glide_reach", {8'h0, osc_pitch_val}, 32'h200000);
    visit(0, 1, 24'h001000);
    visit(0, 2, 24'h001000);
    visit(0, 3, 24'h001000);
    visit(6, 0, 0);
    visit(6, 0, 0);
    check("glide_fall", {31'h0, glide_active[0]}, 32'h0);

    // legato-only mode
    cfg(1'b1, 8'h02);
    visit(3, 0, 24'h050000);
    visit(3, 0, 24'h050000);
    key(3, 1'b0);
    visit(7, 0, 0);
    visit(3, 0, 24'h090000);
    visit(7, 1, 0);
    check("leg0_jump", {8'h0, osc_pitch_val}, 32'h090000);
    key(3, 1'b1);
    visit(7, 2, 0);
    visit(3, 0, 24'h010000);
    visit(7, 3, 0);
    check("leg1_glide", {8'h0, osc_pitch_val}, 32'h088000);

    // shift 15: unit steps up and down
    cfg(1'b0, 8'h0F);
    visit(4, 0, 1000);
    cfg(1'b1, 8'h01);
    visit(4, 0, 1000);
    key(4, 1'b0);
    visit(6, 1, 0);
    for (k = 1; k <= 6; k++) begin
      visit(4, 0, 1005);
      if (k >= 2) check("unit_up", {8'h0, osc_pitch_val}, 32'(999 + k));
    end
    visit(6, 1, 0);
    check("unit_top", {8'h0, osc_pitch_val}, 32'd1005);
    key(4, 1'b0);
    visit(6, 2, 0);
    for (k = 1; k <= 6; k++) begin
      visit(4, 0, 1000);
      if (k >= 2) check("unit_dn", {8'h0, osc_pitch_val}, 32'(1006 - k));
    end
    visit(6, 1, 0);
    check("unit_bot", {8'h0, osc_pitch_val}, 32'd1000);

    // reset mid-glide
    cfg(1'b0, 8'h04);
    visit(5, 0, 24'h100000);
    visit(5, 0, 24'h100000);
    key(5, 1'b0);
    visit(6, 0, 0);
    visit(5, 0, 24'h800000);
    visit(5, 0, 24'h800000);
    visit(5, 0, 24'h800000);
    check("pre_rst_act", {31'h0, glide_active[5]}, 32'h1);
    reset = 1'b1;
    #1;
    model_reset();
    check("mid_rst_osc", {8'h0, osc_pitch_val}, 32'h0);
    check("mid_rst_gact", {24'h0, glide_active}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    visit(5, 0, 24'h800000);
    visit(6, 0, 0);
    check("post_rst_snap", {8'h0, osc_pitch_val}, 32'h800000);
    visit(6, 1, 0);
    check("post_rst_act", {31'h0, glide_active[5]}, 32'h0);

    // random traffic
    for (int i = 0; i < 32; i++) tb_tgt[i] = longint'($urandom_range(0, 24'hFFFFFF));
    lv = 0; lo = 0;
    for (int n = 0; n < 1500; n++) begin
      int sl;
      if ($urandom_range(0, 3) != 0) begin
        lv = $urandom_range(0, 7);
        lo = $urandom_range(0, 3);
      end
      sl = lv * 4 + lo;
      case ($urandom_range(0, 19))
        0:    tb_tgt[sl] = longint'($urandom_range(0, 24'hFFFFFF));
        1, 2: tb_tgt[sl] = (tb_tgt[sl] + longint'($urandom_range(0, 511)) - 256) & 24'hFFFFFF;
        default: ;
      endcase
      if ($urandom_range(0, 15) == 0) key($urandom_range(0, 7), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 31) == 0) cfg(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      visit(lv, lo, 32'(tb_tgt[sl]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
